hazard_sched: RTL and testbench
===============================

// Module: hazard_sched
// PURPOSE
//  Pipeline interlock scheduler for the decode stage. Tracks in-flight register writes in a 3-entry scoreboard (EX, MEM, WB).
//  Detects RAW/load-use hazards against the instruction in ID and drives the decode NOP-insertion and stall controls.
//  Freezes the whole pipe while data memory is not done. Handles branch flush, including a flush that arrives during a freeze.
// PARAMETERS
//  FWD_EN   1   1: EX/MEM forwarding exists, only load-use stalls; 0: stall until producer reaches WB
//  CNT_W    16  width of saturating stall-cycle counter
// PORTS
//  clk          in   1      clock; single clock domain
//  rst          in   1      asynchronous reset, active-high
//  id_valid     in   1      ID holds a real instruction
//  id_rs        in   3      ID source reg 1 (instr[10:8])
//  id_rs_used   in   1      ID reads rs
//  id_rt        in   3      ID source reg 2 (instr[7:5])
//  id_rt_used   in   1      ID reads rt
//  id_rd        in   3      ID destination reg (post RegDst mux)
//  id_regwrt    in   1      ID writes a register
//  id_memread   in   1      ID is a load
//  flush        in   1      branch taken in EX; kill ID/IF contents
//  dm_done      in   1      data memory completed (Done_DM); 0 while a MEM access is pending
//  dm_active    in   1      MEM stage holds a memory access this cycle
//  stall_id     out  1      hold PC and IF/ID register
//  nop_mech     out  1      force decode control to NOP (bubble into EX)
//  freeze       out  1      hold every pipeline register
//  state        out  2      00 RUN, 01 HAZ, 10 MWAIT
//  stall_cnt    out  CNT_W  cycles with stall_id|freeze, saturating
// BEHAVIOUR
//  Reset: all scoreboard entries invalid; state=RUN; stall_cnt=0; stall_id=nop_mech=freeze=0.
//  Scoreboard entry = {v, rd[2:0], ld}. No register is exempt; R0 is a real register.
//  match(e) = e.v & ((id_rs_used & id_rs==e.rd) | (id_rt_used & id_rt==e.rd)).
//  hazard: FWD_EN=1 -> match(EX) & EX.ld. FWD_EN=0 -> match(EX) | match(MEM).
//   The WB entry never causes a hazard; the regfile bypass covers it.
//  flush_eff = flush | flush_pend.
//  Outputs, combinational from current state and inputs:
//   freeze   = dm_active & ~dm_done
//   stall_id = ~freeze & id_valid & hazard & ~flush_eff
//   nop_mech = stall_id | (~freeze & flush_eff)
//  Scoreboard update on each clk edge with freeze=0:
//   WB <= MEM; MEM <= EX
//   EX <= (id_valid & ~stall_id & ~flush_eff) ? {id_regwrt, id_rd, id_memread} : invalid
//  Scoreboard with freeze=1: all entries hold.
//  flush_pend:
//   set when flush=1 & freeze=1
//   cleared on the first clock edge with freeze=0
//   flush_pend=1 & flush=1 together is a single flush.
//  FSM next state, priority order:
//   1. freeze -> MWAIT
//   2. stall_id -> HAZ
//   3. otherwise -> RUN
//   Load-use with FWD_EN=1 spends exactly 1 cycle in HAZ. With FWD_EN=0: 2 cycles if producer in EX, 1 if in MEM.
//   MWAIT -> RUN/HAZ on the edge after dm_done=1, re-evaluating the hazard from the held scoreboard.
//  Simultaneous events:
//   flush beats hazard: no stall, bubble issued, state RUN.
//   freeze beats all: stall_id=0 while freeze=1.
//  stall_cnt increments on each edge where stall_id|freeze; it holds at all-ones.
//  rst asserted mid-operation: immediate return to reset values; flush_pend cleared.
// TESTING
//  1. FWD_EN=1: LD r1 then ADD r2,r1,r3 -> stall_id=nop_mech=1 for 1 cycle; state RUN->HAZ->RUN; stall_cnt=1.
//  2. FWD_EN=0: ADD r1 then SUB r4,r1,r1 -> stall 2 cycles. Insert 1 independent instr in between -> stall 1 cycle.
//  3. dm_active=1, dm_done=0 for 3 cycles -> freeze=1 for 3 cycles; scoreboard unchanged; stall_cnt +3.
//  4. flush=1 in the same cycle as a load-use hazard -> stall_id=0, nop_mech=1, EX entry invalid, state RUN.
//  5. flush=1 during freeze, then dm_done=1 -> nop_mech=1 on the first unfrozen cycle; flush_pend clears after it.
//  6. rst pulse mid-HAZ with stall_cnt at all-ones -> all outputs 0 asynchronously. Separately: saturated counter stays at all-ones.

Source files
------------

// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - decode-stage interlock scheduler
// Tracks in-flight writes (EX/MEM/WB), raises stall/bubble/freeze controls and flush handling.
module hazard_sched #(
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [2:0]       id_rs,
  input  logic             id_rs_used,
  input  logic [2:0]       id_rt,
  input  logic             id_rt_used,
  input  logic [2:0]       id_rd,
  input  logic             id_regwrt,
  input  logic             id_memread,
  input  logic             flush,
  input  logic             dm_done,
  input  logic             dm_active,
  output logic             stall_id,
  output logic             nop_mech,
  output logic             freeze,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    HAZ   = 2'b01,
    MWAIT = 2'b10
  } state_t;

  typedef struct packed {
    logic       v;
    logic [2:0] rd;
    logic       ld;
  } sb_t;

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  state_t cur, nxt;
  sb_t    sb [3];
  logic   flush_pend;
  logic   flush_eff;
  logic   hazard;

  function automatic logic match(input sb_t e);
    return e.v & ((id_rs_used & (id_rs == e.rd)) | (id_rt_used & (id_rt == e.rd)));
  endfunction

  // WB is never consulted: the register file bypass covers it.
  always_comb begin
    hazard = 1'b0;
    if (FWD_EN) hazard = match(sb[EX]) & sb[EX].ld;
    else        hazard = match(sb[EX]) | match(sb[MEM]);
  end

  assign freeze    = dm_active & ~dm_done;
  assign flush_eff = flush | flush_pend;
  assign stall_id  = ~freeze & id_valid & hazard & ~flush_eff;
  assign nop_mech  = stall_id | (~freeze & flush_eff);
  assign state     = cur;

  always_comb begin
    nxt = RUN;
    if (freeze)        nxt = MWAIT;
    else if (stall_id) nxt = HAZ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= RUN;
    else     cur <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) sb[i] <= '0;
      flush_pend <= 1'b0;
    end else if (!freeze) begin
      sb[WB]     <= sb[MEM];
      sb[MEM]    <= sb[EX];
      sb[EX]     <= (id_valid & ~stall_id & ~flush_eff)
                    ? sb_t'{v: id_regwrt, rd: id_rd, ld: id_memread} : sb_t'('0);
      flush_pend <= 1'b0;
    end else if (flush) begin
      // Remember the kill so it takes effect on the first unfrozen cycle.
      flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if ((stall_id | freeze) && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - scoreboard bench for hazard_sched
// Two instances share stimulus: u1 (forwarding, 3-bit counter) and u0 (no forwarding).
module tb_hazard_sched;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_rs_used, id_rt_used, id_regwrt, id_memread;
  logic [2:0] id_rs, id_rt, id_rd;
  logic flush, dm_done, dm_active;

  logic stall1, nop1, frz1, stall0, nop0, frz0;
  logic [1:0] st1, st0;
  logic [2:0] cnt1;
  logic [15:0] cnt0;
  logic [20:0] v1, v0;

  typedef struct {
    bit          sel;
    logic [20:0] exp;
    string       nm;
  } rec_t;

  rec_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  localparam logic [1:0] RUN = 2'b00, HAZ = 2'b01, MWAIT = 2'b10;

  always #5 clk = ~clk;

  hazard_sched #(.FWD_EN(1'b1), .CNT_W(3)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_regwrt(id_regwrt),
    .id_memread(id_memread), .flush(flush), .dm_done(dm_done), .dm_active(dm_active),
    .stall_id(stall1), .nop_mech(nop1), .freeze(frz1), .state(st1), .stall_cnt(cnt1)
  );

  hazard_sched #(.FWD_EN(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_regwrt(id_regwrt),
    .id_memread(id_memread), .flush(flush), .dm_done(dm_done), .dm_active(dm_active),
    .stall_id(stall0), .nop_mech(nop0), .freeze(frz0), .state(st0), .stall_cnt(cnt0)
  );

  assign v1 = {stall1, nop1, frz1, st1, 13'b0, cnt1};
  assign v0 = {stall0, nop0, frz0, st0, cnt0};

  function automatic logic [20:0] e(bit s, bit n, bit f, logic [1:0] st, int c);
    return {s, n, f, st, 16'(c)};
  endfunction

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rs_used = 0; id_rt = 0; id_rt_used = 0;
    id_rd = 0; id_regwrt = 0; id_memread = 0;
    flush = 0; dm_active = 0; dm_done = 1;
  endtask

  task automatic set_id(input logic [2:0] rs, input bit rsu, input logic [2:0] rt,
                        input bit rtu, input logic [2:0] rd, input bit rw, input bit mr);
    id_valid = 1; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_rd = rd; id_regwrt = rw; id_memread = mr;
  endtask

  task automatic push(input bit sel, input logic [20:0] exp, input string nm);
    rec_t r;
    r.sel = sel; r.exp = exp; r.nm = nm;
    q.push_back(r);
  endtask

  task automatic cyc(input bit sel, input logic [20:0] exp, input string nm);
    push(sel, exp, nm);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1; #2; rst = 0;
    @(posedge clk); #1;
  endtask

  // Monitor: samples mid-cycle, or just after an asynchronous reset edge.
  initial begin
    rec_t r;
    logic [20:0] act;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      if (q.size() > 0) begin
        r = q.pop_front();
        act = r.sel ? v1 : v0;
        n_vec++;
        if (act !== r.exp) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h (u%0d)", r.nm, act, r.exp, r.sel);
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    cyc(1, e(0,0,0,RUN,0), "reset_u1");
    cyc(0, e(0,0,0,RUN,0), "reset_u0");

    // load-use with forwarding
    do_reset();
    set_id(0,0,0,0,1,1,1); cyc(1, e(0,0,0,RUN,0), "t1_ld");
    set_id(1,1,3,1,2,1,0); cyc(1, e(1,1,0,RUN,0), "t1_stall");
    cyc(1, e(0,0,0,HAZ,1), "t1_haz");
    idle();               cyc(1, e(0,0,0,RUN,1), "t1_run");

    // no forwarding, back-to-back dependency
    do_reset();
    set_id(6,1,7,1,1,1,0); cyc(0, e(0,0,0,RUN,0), "t2a_add");
    set_id(1,1,1,1,4,1,0); cyc(0, e(1,1,0,RUN,0), "t2a_st1");
    cyc(0, e(1,1,0,HAZ,1), "t2a_st2");
    cyc(0, e(0,0,0,HAZ,2), "t2a_go");
    idle();               cyc(0, e(0,0,0,RUN,2), "t2a_run");

    // no forwarding, one independent instruction between
    do_reset();
    set_id(6,1,7,1,1,1,0); cyc(0, e(0,0,0,RUN,0), "t2b_add");
    set_id(6,1,7,1,5,1,0); cyc(0, e(0,0,0,RUN,0), "t2b_indep");
    set_id(1,1,1,1,4,1,0); cyc(0, e(1,1,0,RUN,0), "t2b_st1");
    cyc(0, e(0,0,0,HAZ,1), "t2b_go");
    idle();               cyc(0, e(0,0,0,RUN,1), "t2b_run");

    // freeze holds the scoreboard; load-use resolves afterwards
    do_reset();
    set_id(0,0,0,0,1,1,1); cyc(1, e(0,0,0,RUN,0), "t3_ld");
    set_id(1,1,3,1,2,1,0); dm_active = 1; dm_done = 0;
    cyc(1, e(0,0,1,RUN,0),   "t3_frz1");
    cyc(1, e(0,0,1,MWAIT,1), "t3_frz2");
    cyc(1, e(0,0,1,MWAIT,2), "t3_frz3");
    dm_done = 1;          cyc(1, e(1,1,0,MWAIT,3), "t3_unfrz");
    dm_active = 0;        cyc(1, e(0,0,0,HAZ,4), "t3_haz");
    idle();               cyc(1, e(0,0,0,RUN,4), "t3_run");

    // flush beats load-use hazard
    do_reset();
    set_id(0,0,0,0,1,1,1); cyc(1, e(0,0,0,RUN,0), "t4_ld");
    set_id(1,1,3,1,2,1,0); flush = 1; cyc(1, e(0,1,0,RUN,0), "t4_flush");
    flush = 0;            cyc(1, e(0,0,0,RUN,0), "t4_ex_inv");

    // flush during freeze is applied on the first unfrozen cycle
    do_reset();
    dm_active = 1; dm_done = 0; flush = 1; cyc(1, e(0,0,1,RUN,0), "t5_frz_fl");
    flush = 0;            cyc(1, e(0,0,1,MWAIT,1), "t5_frz");
    dm_done = 1; set_id(1,1,3,1,2,1,0); cyc(1, e(0,1,0,MWAIT,2), "t5_pend");
    dm_active = 0; set_id(2,1,2,1,4,1,0); cyc(1, e(0,0,0,RUN,2), "t5_clear");

    // saturation, then async reset mid-HAZ with counter at all-ones
    do_reset();
    dm_active = 1; dm_done = 0;
    for (int k = 0; k < 10; k++)
      cyc(1, e(0,0,1, (k == 0) ? RUN : MWAIT, (k > 7) ? 7 : k), "t6_sat");
    idle(); set_id(0,0,0,0,1,1,1); cyc(1, e(0,0,0,MWAIT,7), "t6_ld");
    set_id(1,1,3,1,2,1,0); cyc(1, e(1,1,0,RUN,7), "t6_stall");
    push(1, e(0,0,0,HAZ,7), "t6_haz_sat");
    @(negedge clk); #2;
    push(1, e(0,0,0,RUN,0), "t6_async_rst");
    rst = 1;
    @(posedge clk); #1;
    rst = 0; idle();
    cyc(1, e(0,0,0,RUN,0), "t6_post_rst");

    @(negedge clk); #2;
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
